// File: rtl/if_pkg.sv
// if_pkg: shared fetch-stage state encoding and constants
package if_pkg;
  typedef enum logic [1:0] {FETCH, WAIT, DROP} state_e;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
endpackage

// File: rtl/if_stage.sv
// if_stage: instruction fetch with one outstanding request, branch redirect and decode-side stall
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, req_pc_q, req_pc_d, inst_q, inst_d, inst_pc_q, inst_pc_d;
  logic        inst_valid_q, inst_valid_d, fire, load, unused_ok;
  assign unused_ok      = ^br_target[1:0];
  assign imem_req_valid = !rst && state_q == FETCH && !br_taken && (!inst_valid_q || !stall);
  assign imem_req_addr  = pc_q;
  assign fire           = imem_req_valid && imem_req_ready;
  assign load           = state_q == WAIT && imem_rsp_valid && !br_taken;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_valid_q ? inst_q : NOP_INST;
  assign inst_pc        = inst_pc_q;
  always_comb begin
    state_d      = state_q == FETCH ? (fire ? WAIT : FETCH)
                 : imem_rsp_valid ? FETCH
                 : (state_q == WAIT && br_taken) ? DROP : state_q;
    pc_d         = br_taken ? {br_target[31:2], 2'b00} : load ? req_pc_q + 32'd4 : pc_q;
    req_pc_d     = fire ? pc_q : req_pc_q;
    inst_d       = load ? imem_rsp_data : inst_q;
    inst_pc_d    = load ? req_pc_q : inst_pc_q;
    inst_valid_d = load || (inst_valid_q && stall && !br_taken);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      inst_q       <= NOP_INST;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed checks of fetch, stall, redirect, wrap and reset behaviour
module tb_if_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        stall = 1'b0;
  logic        inst_valid;
  logic [31:0] inst, inst_pc;
  int          n_chk = 0, n_fail = 0;

  if_stage dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .br_taken(br_taken), .br_target(br_target), .stall(stall),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_inst_pc", inst_pc, 32'h0);
    step(); step();
    rst = 1'b0;
    imem_req_ready = 1'b1;
    #1;
    chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h0);
    step();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0050_0093;
    #1;
    chk("wait_no_req", {31'b0, imem_req_valid}, 32'd0);
    step();
    imem_rsp_valid = 1'b0; stall = 1'b1; imem_req_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_inst_valid", {31'b0, inst_valid}, 32'd1);
      chk("stall_inst", inst, 32'h0050_0093);
      chk("stall_inst_pc", inst_pc, 32'h0);
      chk("stall_no_req", {31'b0, imem_req_valid}, 32'd0);
      chk("stall_addr", imem_req_addr, 32'h4);
      step();
    end
    stall = 1'b0;
    #1;
    chk("resume_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("resume_addr", imem_req_addr, 32'h4);
    chk("resume_inst_valid", {31'b0, inst_valid}, 32'd1);
    step();
    imem_req_ready = 1'b0; br_taken = 1'b1; br_target = 32'h0000_0103;
    #1;
    chk("consumed_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("br_wait_no_req", {31'b0, imem_req_valid}, 32'd0);
    step();
    br_taken = 1'b0;
    #1;
    chk("drop_no_req", {31'b0, imem_req_valid}, 32'd0);
    step();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    #1;
    chk("drop_rsp_no_req", {31'b0, imem_req_valid}, 32'd0);
    step();
    imem_rsp_valid = 1'b0; imem_req_ready = 1'b1;
    #1;
    chk("drop_discard_valid", {31'b0, inst_valid}, 32'd0);
    chk("drop_discard_inst", inst, 32'h0000_0013);
    chk("redir_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("redir_addr", imem_req_addr, 32'h100);
    step();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_1111;
    br_taken = 1'b1; br_target = 32'h0000_0200;
    #1;
    chk("br_rsp_no_req", {31'b0, imem_req_valid}, 32'd0);
    step();
    br_taken = 1'b0; imem_rsp_valid = 1'b0;
    #1;
    chk("br_rsp_drop_valid", {31'b0, inst_valid}, 32'd0);
    chk("br_rsp_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("br_rsp_addr", imem_req_addr, 32'h200);
    br_taken = 1'b1; br_target = 32'hFFFF_FFFF;
    #1;
    chk("br_fetch_no_req", {31'b0, imem_req_valid}, 32'd0);
    step();
    br_taken = 1'b0; imem_req_ready = 1'b1;
    #1;
    chk("wrap_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    step();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0073;
    step();
    imem_rsp_valid = 1'b0;
    #1;
    chk("wrap_inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("wrap_inst", inst, 32'h0000_0073);
    chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC);
    chk("wrap_next_addr", imem_req_addr, 32'h0);
    chk("wrap_next_valid", {31'b0, imem_req_valid}, 32'd1);
    step();
    imem_req_ready = 1'b1;
    #1;
    chk("wrap_consumed", {31'b0, inst_valid}, 32'd0);
    chk("wrap_consumed_inst", inst, 32'h0000_0013);
    step();
    imem_req_ready = 1'b0; rst = 1'b1;
    #1;
    chk("midrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("midrst_inst_valid", {31'b0, inst_valid}, 32'd0);
    step();
    rst = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h2222_2222;
    #1;
    chk("late_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("late_req_addr", imem_req_addr, 32'h0);
    step();
    imem_rsp_valid = 1'b0;
    #1;
    chk("late_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("late_inst", inst, 32'h0000_0013);
    chk("late_addr", imem_req_addr, 32'h0);
    chk("late_req_valid2", {31'b0, imem_req_valid}, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
